// File: rtl/div_op_sequencer_pkg.sv
// Shared types and constants for the CompDivider operand-feed / result-capture sequencer.
package div_pkg;

  localparam int DIV_W = 32;
  localparam int DIV_TIMEOUT_DEFAULT = 64;
  localparam logic [DIV_W-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_GAP,
    ST_RUN,
    ST_OUT
  } div_seq_state_t;

endpackage

// File: rtl/div_op_sequencer_if.sv
// Request/result handshake bundle of div_op_sequencer; the sequencer uses the slave side.
interface div_op_sequencer_if;
  import div_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [DIV_W-1:0] in_dividend;
  logic [DIV_W-1:0] in_divisor;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [DIV_W-1:0] out_quotient;
  logic [DIV_W-1:0] out_remainder;
  logic             out_div0;
  logic             out_timeout;

  modport master (
    output in_valid, in_dividend, in_divisor, in_signed, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder, out_div0, out_timeout
  );

  modport slave (
    input  in_valid, in_dividend, in_divisor, in_signed, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder, out_div0, out_timeout
  );

endinterface

// File: rtl/div_op_sequencer_sign_fix.sv
// div_sign_fix: magnitude conversion of operands and sign restoration of divider results.
// Only present when DIV_SIGNED_EN is defined.
`ifdef DIV_SIGNED_EN
module div_sign_fix
  import div_pkg::*;
(
  input  logic             is_signed,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  input  logic [DIV_W-1:0] raw_quotient,
  input  logic [DIV_W-1:0] raw_remainder,
  output logic [DIV_W-1:0] abs_dividend,
  output logic [DIV_W-1:0] abs_divisor,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder
);

  logic neg_dividend;
  logic neg_divisor;

  assign neg_dividend = is_signed && dividend[DIV_W-1];
  assign neg_divisor  = is_signed && divisor[DIV_W-1];

  assign abs_dividend = neg_dividend ? -dividend : dividend;
  assign abs_divisor  = neg_divisor  ? -divisor  : divisor;

  // Remainder follows the dividend's sign so that q*d + r reproduces the dividend.
  assign quotient  = (neg_dividend ^ neg_divisor) ? -raw_quotient : raw_quotient;
  assign remainder = neg_dividend ? -raw_remainder : raw_remainder;

endmodule
`endif

// File: rtl/div_op_sequencer.sv
// Drives CompDivider's Reset/Run/Ready protocol for one request at a time and holds the result.
// Optional signed operation is enabled with the DIV_SIGNED_EN macro.
module div_op_sequencer
  import div_pkg::*;
#(
  parameter int TIMEOUT = DIV_TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               Reset,
  div_op_sequencer_if.slave  io,
  output logic               div_Reset,
  output logic               div_Run,
  output logic [DIV_W-1:0]   div_Dividend,
  output logic [DIV_W-1:0]   div_Divisor,
  input  logic [2*DIV_W-1:0] div_Product,
  input  logic               div_Ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  div_seq_state_t   state;
  div_seq_state_t   state_next;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] op_dividend;
  logic [DIV_W-1:0] op_divisor;
  logic [DIV_W-1:0] res_quotient;
  logic [DIV_W-1:0] res_remainder;
  logic             flag_div0;
  logic             flag_timeout;
  logic             zero_div;
  logic             overflow_div;
  logic             timed_out;
  logic [DIV_W-1:0] fix_dividend;
  logic [DIV_W-1:0] fix_divisor;
  logic [DIV_W-1:0] fix_quotient;
  logic [DIV_W-1:0] fix_remainder;

  assign zero_div  = (io.in_divisor == '0);
  assign timed_out = (cnt >= CNT_LAST);

`ifdef DIV_SIGNED_EN
  localparam logic [DIV_W-1:0] INT_MIN = {1'b1, {(DIV_W-1){1'b0}}};

  logic op_signed;

  // INT_MIN / -1 overflows the quotient, so it is answered directly without the divider.
  assign overflow_div = io.in_signed && (io.in_dividend == INT_MIN) && (io.in_divisor == '1);

  div_sign_fix u_sign_fix (
    .is_signed     (op_signed),
    .dividend      (op_dividend),
    .divisor       (op_divisor),
    .raw_quotient  (div_Product[DIV_W-1:0]),
    .raw_remainder (div_Product[2*DIV_W-1:DIV_W]),
    .abs_dividend  (fix_dividend),
    .abs_divisor   (fix_divisor),
    .quotient      (fix_quotient),
    .remainder     (fix_remainder)
  );
`else
  logic unused_in_signed;

  assign unused_in_signed = io.in_signed;
  assign overflow_div     = 1'b0;
  assign fix_dividend     = op_dividend;
  assign fix_divisor      = op_divisor;
  assign fix_quotient     = div_Product[DIV_W-1:0];
  assign fix_remainder    = div_Product[2*DIV_W-1:DIV_W];
`endif

  always_ff @(posedge clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (io.in_valid) state_next = (zero_div || overflow_div) ? ST_OUT : ST_CLR;
      ST_CLR:  state_next = ST_GAP;
      ST_GAP:  state_next = ST_RUN;
      ST_RUN:  if (div_Ready || timed_out) state_next = ST_OUT;
      ST_OUT:  if (io.out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Reset overrides the state decode so the divider is held cleared and nothing handshakes.
  always_comb begin
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    div_Reset    = Reset;
    div_Run      = 1'b0;
    if (!Reset) begin
      case (state)
        ST_IDLE: io.in_ready  = 1'b1;
        ST_CLR:  div_Reset    = 1'b1;
        ST_RUN:  div_Run      = 1'b1;
        ST_OUT:  io.out_valid = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      op_dividend   <= '0;
      op_divisor    <= '0;
      res_quotient  <= '0;
      res_remainder <= '0;
      flag_div0     <= 1'b0;
      flag_timeout  <= 1'b0;
      cnt           <= '0;
`ifdef DIV_SIGNED_EN
      op_signed     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (io.in_valid) begin
            op_dividend  <= io.in_dividend;
            op_divisor   <= io.in_divisor;
            flag_div0    <= 1'b0;
            flag_timeout <= 1'b0;
`ifdef DIV_SIGNED_EN
            op_signed    <= io.in_signed;
`endif
            if (zero_div) begin
              res_quotient  <= DIV0_QUOTIENT;
              res_remainder <= io.in_dividend;
              flag_div0     <= 1'b1;
            end else if (overflow_div) begin
              res_quotient  <= io.in_dividend;
              res_remainder <= '0;
            end
          end
        end
        ST_GAP: cnt <= '0;
        ST_RUN: begin
          if (div_Ready) begin
            res_quotient  <= fix_quotient;
            res_remainder <= fix_remainder;
          end else if (timed_out) begin
            res_quotient  <= '0;
            res_remainder <= '0;
            flag_timeout  <= 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_OUT: begin
          if (io.out_ready) begin
            flag_div0    <= 1'b0;
            flag_timeout <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign div_Dividend     = fix_dividend;
  assign div_Divisor      = fix_divisor;
  assign io.out_quotient  = res_quotient;
  assign io.out_remainder = res_remainder;
  assign io.out_div0      = flag_div0;
  assign io.out_timeout   = flag_timeout;

endmodule

// File: doc/div_op_sequencer.md
# div_op_sequencer

Operand-feed and result-capture stage wrapped around the sequential `CompDivider`. Accepts divide requests on a valid/ready handshake and drives the divider's `Reset`/`Run`/`Ready` protocol: clear one cycle, idle one cycle, hold `Run` until `Ready`. Captures quotient/remainder and presents them on a valid/ready output. Also handles divide-by-zero, divider timeout, and optionally signed operands.

## Interface
- `TIMEOUT`, 64: maximum cycles in RUN waiting for `div_Ready` before an error completion.
- `clk`  in  1  single clock, all logic on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  sequencer can accept a request (high only in IDLE).
- `in_dividend`  in  32  dividend.
- `in_divisor`  in  32  divisor.
- `in_signed`  in  1  treat operands as two's complement; ignored unless `DIV_SIGNED_EN`.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes result.
- `out_quotient`  out  32  quotient.
- `out_remainder`  out  32  remainder.
- `out_div0`  out  1  divisor was zero.
- `out_timeout`  out  1  divider never raised Ready.
- `div_Reset`  out  1  to divider `Reset`.
- `div_Run`  out  1  to divider `Run`.
- `div_Dividend`  out  32  to divider `Multiplicand_in`.
- `div_Divisor`  out  32  to divider `Multiplier_in`.
- `div_Product`  in  64  from divider `Product_out`: [63:32] remainder, [31:0] quotient.
- `div_Ready`  in  1  from divider `Ready`.

## Operation
- States: IDLE, CLR, GAP, RUN, OUT.
- IDLE: `in_ready`=1. On `in_valid`, latch the operands and `in_signed`.
  - Divisor nonzero → CLR.
  - Divisor zero → OUT with quotient 32'hFFFF_FFFF, remainder = raw dividend, `out_div0`=1. The divider is not started.
- CLR: `div_Reset`=1 for exactly one cycle → GAP.
- GAP: `div_Reset`=0, `div_Run`=0 for one cycle. Clear the timeout counter → RUN.
- RUN: `div_Run`=1, counter increments each cycle.
  - First cycle with `div_Ready`=1: capture `div_Product` → OUT.
  - Counter reaches `TIMEOUT` with no Ready: quotient=0, remainder=0, `out_timeout`=1 → OUT.
  - `div_Run` drops when leaving RUN.
- OUT: `out_valid`=1, result registers held stable. On `out_ready`, go to IDLE and clear the flags.
- `div_Dividend`/`div_Divisor` are driven from the latched (sign-adjusted) operands and held stable CLR through RUN.
- Only one request is in flight; no buffering beyond the single result register.

## Timing
- Reset values: `in_ready`=0 during the reset cycle and 1 after; `out_valid`=0; quotient/remainder/flags=0; `div_Reset`=1; `div_Run`=0; `div_Dividend`/`div_Divisor`=0; state IDLE.
- Accept at edge T0. CLR during T0+1, GAP during T0+2, RUN from T0+3.
- If `div_Ready` is sampled high at edge T0+3+N, `out_valid` is high from that edge.
- Divide-by-zero: `out_valid` high the cycle after accept.
- `out_valid` and `out_ready` both high at an edge: the result retires, and `in_ready` is high the following cycle. There is no same-cycle re-accept.
- `div_Ready` already high in the first RUN cycle (stale): it is captured. This is legal because CLR has reset the divider.
- `Reset` in any state: abort to IDLE next edge, `div_Run`=0, `div_Reset`=1 that cycle, pending result discarded.
- Timeout counter is `$clog2(TIMEOUT+1)` bits and saturates; it never wraps.

## Configuration
- `DIV_SIGNED_EN` defined, `in_signed`=1:
  - Operands are converted to magnitudes before driving the divider.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 32'h8000_0000 / 32'hFFFF_FFFF yields quotient 32'h8000_0000, remainder 0, with no divider run (same latency as div0, `out_div0`=0).
  - Signed divide-by-zero returns the raw dividend as remainder.
- `DIV_SIGNED_EN` undefined: `in_signed` is ignored and all division is unsigned. The sign-fix logic is absent.

## Structure
- Package `div_pkg`:
  - state enum `div_seq_state_t`
  - `DIV_TIMEOUT_DEFAULT` (64)
  - `DIV0_QUOTIENT` (32'hFFFF_FFFF)
  - width constant `DIV_W` (32)
- Sub-module `div_sign_fix` (combinational, only under `DIV_SIGNED_EN`): pre-abs of operands and post-negation of results.

## Test plan
- Unsigned 100/7: `div_Reset` pulse T0+1, `div_Run` from T0+3 → quotient 14, remainder 2, flags 0.
- Divisor 0, dividend 32'h0000_1234 → `out_valid` at T0+1, quotient 32'hFFFF_FFFF, remainder 32'h1234, `out_div0`=1, `div_Run` never high.
- Divider model never raises Ready, `TIMEOUT`=8 → `out_timeout`=1 after 8 RUN cycles, `div_Run` low next cycle.
- `out_ready` held low for 5 cycles → outputs stable and `in_ready`=0 throughout; on release, next request (50/5) accepted → quotient 10, remainder 0.
- `Reset` asserted mid-RUN → next cycle IDLE, `div_Run`=0, `out_valid`=0. A following 9/4 completes → quotient 2, remainder 1.
- `DIV_SIGNED_EN`, `in_signed`=1:
  - -7/2 → quotient -3 (32'hFFFF_FFFD), remainder -1.
  - 32'h8000_0000/-1 → quotient 32'h8000_0000, remainder 0.
